ctrl_pipe: RTL and testbench

- Parametrised successor to the combinational MIPS control decoder.
- Decodes opcode/funct in ID and carries the control bundle through pipeline registers ID/EX, EX/MEM and MEM/WB.
- Adds load-use interlock, jump/branch flush, optional I-type ALU op decode, illegal-opcode detection, and stall/flush performance counters.
- Sits between the IF/ID register and the datapath stage muxes of the 5-stage core.

---
 rtl/ctrl_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined MIPS control unit.
// Decodes the ID instruction and carries its control bundle through ID/EX,
// EX/MEM and MEM/WB. Also handles the load-use interlock, jump/branch flush,
// illegal-opcode detection and saturating stall/flush counters.
module ctrl_pipe #(
  parameter int REG_AW  = 5,
  parameter bit EXT_OPS = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              id_signext,
  output logic              illegal,
  output logic              stall,
  output logic              flush_ifid,
  output logic              pc_jump,
  output logic              pc_jumpr,
  output logic              ex_br_taken,
  output logic [2:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_branchne,
  output logic              ex_link,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_memtoreg,
  output logic              mem_regwrite,
  output logic              mem_link,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic              wb_link,
  output logic [REG_AW-1:0] wb_wreg,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              illegal_seen
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RFN  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;

  // jal always links into $31
  localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(31);

  // decoded ID bundle
  logic              w_mapped;
  logic [2:0]        w_aluop;
  logic              w_alusrc;
  logic              w_branch;
  logic              w_branchne;
  logic              w_jump;
  logic              w_jumpr;
  logic              w_link;
  logic              w_memread;
  logic              w_memwrite;
  logic              w_memtoreg;
  logic              w_regwrite;
  logic              w_signext;
  logic [REG_AW-1:0] w_dest;
  logic              w_reads_rs;
  logic              w_reads_rt;

  // hazard / steering
  logic              w_illegal;
  logic              w_br_taken;
  logic              w_hazard;
  logic              w_id_jump;
  logic              w_stall;
  logic              w_flush;
  logic              w_pc_jump;
  logic              w_issue;
  logic [1:0]        w_cnt_inc;

  // ID/EX
  logic [2:0]        r_ex_aluop;
  logic              r_ex_alusrc;
  logic              r_ex_branch;
  logic              r_ex_branchne;
  logic              r_ex_link;
  logic              r_ex_memread;
  logic              r_ex_memwrite;
  logic              r_ex_memtoreg;
  logic              r_ex_regwrite;
  logic [REG_AW-1:0] r_ex_wreg;

  // EX/MEM
  logic              r_mem_memread;
  logic              r_mem_memwrite;
  logic              r_mem_memtoreg;
  logic              r_mem_regwrite;
  logic              r_mem_link;
  logic [REG_AW-1:0] r_mem_wreg;

  // MEM/WB
  logic              r_wb_memtoreg;
  logic              r_wb_regwrite;
  logic              r_wb_link;
  logic [REG_AW-1:0] r_wb_wreg;

  logic              r_illegal_seen;

  // Opcode/funct decode into the control bundle and source-usage flags.
  // The I-ALU group is only recognised when EXT_OPS is set; otherwise it
  // falls through as unmapped and is reported illegal.
  always_comb begin
    w_mapped   = 1'b0;
    w_aluop    = ALU_ADD;
    w_alusrc   = 1'b0;
    w_branch   = 1'b0;
    w_branchne = 1'b0;
    w_jump     = 1'b0;
    w_jumpr    = 1'b0;
    w_link     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_signext  = 1'b0;
    w_dest     = '0;
    w_reads_rs = 1'b0;
    w_reads_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        w_mapped   = 1'b1;
        w_aluop    = ALU_RFN;
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
        if (funct == FN_JR) begin
          w_jump  = 1'b1;
          w_jumpr = 1'b1;
        end else begin
          w_regwrite = 1'b1;
          w_dest     = id_rd;
        end
      end
      OP_LW: begin
        w_mapped   = 1'b1;
        w_alusrc   = 1'b1;
        w_memread  = 1'b1;
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_dest     = id_rt;
        w_reads_rs = 1'b1;
        w_signext  = 1'b1;
      end
      OP_SW: begin
        w_mapped   = 1'b1;
        w_alusrc   = 1'b1;
        w_memwrite = 1'b1;
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
        w_signext  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_mapped   = 1'b1;
        w_aluop    = ALU_SUB;
        w_branch   = 1'b1;
        w_branchne = (opcode == OP_BNE);
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
        w_signext  = 1'b1;
      end
      OP_J: begin
        w_mapped = 1'b1;
        w_jump   = 1'b1;
      end
      OP_JAL: begin
        w_mapped   = 1'b1;
        w_jump     = 1'b1;
        w_link     = 1'b1;
        w_regwrite = 1'b1;
        w_dest     = LINK_REG;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        if (EXT_OPS) begin
          w_mapped   = 1'b1;
          w_alusrc   = 1'b1;
          w_regwrite = 1'b1;
          w_dest     = id_rt;
          // lui has no register source
          w_reads_rs = (opcode != OP_LUI);
          w_signext  = (opcode == OP_ADDI) || (opcode == OP_SLTI);
          case (opcode)
            OP_SLTI: w_aluop = ALU_SLT;
            OP_ANDI: w_aluop = ALU_AND;
            OP_ORI:  w_aluop = ALU_OR;
            OP_LUI:  w_aluop = ALU_LUI;
            default: w_aluop = ALU_ADD;
          endcase
        end
      end
      default: begin
      end
    endcase
  end

  // A branch resolved in EX outranks the interlock, which outranks an ID jump.
  assign w_illegal  = id_valid & ~w_mapped;
  assign w_br_taken = r_ex_branch & (ex_zero ^ r_ex_branchne);
  assign w_hazard   = id_valid & r_ex_memread & r_ex_regwrite & (r_ex_wreg != '0) &
                      ((w_reads_rs & (r_ex_wreg == id_rs)) |
                       (w_reads_rt & (r_ex_wreg == id_rt)));
  assign w_id_jump  = id_valid & w_jump;
  assign w_stall    = ~w_br_taken & w_hazard;
  assign w_pc_jump  = ~w_br_taken & ~w_hazard & w_id_jump;
  assign w_flush    = w_br_taken | w_pc_jump;
  assign w_issue    = id_valid & ~w_illegal & ~w_br_taken & ~w_hazard;
  assign w_cnt_inc  = {w_flush, w_stall};

  // ID/EX: load the decoded bundle, or a bubble when not issuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_aluop    <= ALU_ADD;
      r_ex_alusrc   <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_branchne <= 1'b0;
      r_ex_link     <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_wreg     <= '0;
    end else if (w_issue) begin
      r_ex_aluop    <= w_aluop;
      r_ex_alusrc   <= w_alusrc;
      r_ex_branch   <= w_branch;
      r_ex_branchne <= w_branchne;
      r_ex_link     <= w_link;
      r_ex_memread  <= w_memread;
      r_ex_memwrite <= w_memwrite;
      r_ex_memtoreg <= w_memtoreg;
      r_ex_regwrite <= w_regwrite;
      r_ex_wreg     <= w_dest;
    end else begin
      r_ex_aluop    <= ALU_ADD;
      r_ex_alusrc   <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_branchne <= 1'b0;
      r_ex_link     <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_wreg     <= '0;
    end
  end

  // EX/MEM and MEM/WB advance every cycle; there is no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_link     <= 1'b0;
      r_mem_wreg     <= '0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_link      <= 1'b0;
      r_wb_wreg      <= '0;
    end else begin
      r_mem_memread  <= r_ex_memread;
      r_mem_memwrite <= r_ex_memwrite;
      r_mem_memtoreg <= r_ex_memtoreg;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_link     <= r_ex_link;
      r_mem_wreg     <= r_ex_wreg;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_link      <= r_mem_link;
      r_wb_wreg      <= r_mem_wreg;
    end
  end

  // Sticky illegal flag: only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_seen <= 1'b0;
    end else if (w_illegal) begin
      r_illegal_seen <= 1'b1;
    end
  end

  // Saturating event counters: index 0 counts stalls, index 1 counts flushes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    // count one event per cycle, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_cnt_inc[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign id_signext   = w_signext;
  assign illegal      = w_illegal;
  assign stall        = w_stall;
  assign flush_ifid   = w_flush;
  assign pc_jump      = w_pc_jump;
  assign pc_jumpr     = w_pc_jump & w_jumpr;
  assign ex_br_taken  = w_br_taken;
  assign ex_aluop     = r_ex_aluop;
  assign ex_alusrc    = r_ex_alusrc;
  assign ex_branch    = r_ex_branch;
  assign ex_branchne  = r_ex_branchne;
  assign ex_link      = r_ex_link;
  assign ex_memread   = r_ex_memread;
  assign ex_memwrite  = r_ex_memwrite;
  assign ex_memtoreg  = r_ex_memtoreg;
  assign ex_regwrite  = r_ex_regwrite;
  assign ex_wreg      = r_ex_wreg;
  assign mem_memread  = r_mem_memread;
  assign mem_memwrite = r_mem_memwrite;
  assign mem_memtoreg = r_mem_memtoreg;
  assign mem_regwrite = r_mem_regwrite;
  assign mem_link     = r_mem_link;
  assign mem_wreg     = r_mem_wreg;
  assign wb_memtoreg  = r_wb_memtoreg;
  assign wb_regwrite  = r_wb_regwrite;
  assign wb_link      = r_wb_link;
  assign wb_wreg      = r_wb_wreg;
  assign stall_cnt    = g_cnt[0].r_cnt;
  assign flush_cnt    = g_cnt[1].r_cnt;
  assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scenario tasks for ctrl_pipe with a scoreboard that checks
// the EX and WB stage bundles when each expected entry comes due.
module tb_ctrl_pipe;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic [AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rt = '0;
  logic [AW-1:0] id_rd = '0;
  logic          ex_zero = 1'b0;

  logic          id_signext, illegal, stall, flush_ifid, pc_jump, pc_jumpr, ex_br_taken;
  logic [2:0]    ex_aluop;
  logic          ex_alusrc, ex_branch, ex_branchne, ex_link;
  logic          ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [AW-1:0] ex_wreg;
  logic          mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_link;
  logic [AW-1:0] mem_wreg;
  logic          wb_memtoreg, wb_regwrite, wb_link;
  logic [AW-1:0] wb_wreg;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          illegal_seen;

  logic          z_id_signext, z_illegal, z_stall, z_flush_ifid, z_pc_jump, z_pc_jumpr, z_ex_br_taken;
  logic [2:0]    z_ex_aluop;
  logic          z_ex_alusrc, z_ex_branch, z_ex_branchne, z_ex_link;
  logic          z_ex_memread, z_ex_memwrite, z_ex_memtoreg, z_ex_regwrite;
  logic [AW-1:0] z_ex_wreg;
  logic          z_mem_memread, z_mem_memwrite, z_mem_memtoreg, z_mem_regwrite, z_mem_link;
  logic [AW-1:0] z_mem_wreg;
  logic          z_wb_memtoreg, z_wb_regwrite, z_wb_link;
  logic [AW-1:0] z_wb_wreg;
  logic [CW-1:0] z_stall_cnt, z_flush_cnt;
  logic          z_illegal_seen;

  ctrl_pipe #(.REG_AW(AW), .EXT_OPS(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .id_signext(id_signext), .illegal(illegal), .stall(stall), .flush_ifid(flush_ifid),
    .pc_jump(pc_jump), .pc_jumpr(pc_jumpr), .ex_br_taken(ex_br_taken),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_branchne(ex_branchne), .ex_link(ex_link), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_wreg(ex_wreg), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_link(mem_link),
    .mem_wreg(mem_wreg), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .wb_link(wb_link), .wb_wreg(wb_wreg), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .illegal_seen(illegal_seen)
  );

  ctrl_pipe #(.REG_AW(AW), .EXT_OPS(1'b0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .id_signext(z_id_signext), .illegal(z_illegal), .stall(z_stall), .flush_ifid(z_flush_ifid),
    .pc_jump(z_pc_jump), .pc_jumpr(z_pc_jumpr), .ex_br_taken(z_ex_br_taken),
    .ex_aluop(z_ex_aluop), .ex_alusrc(z_ex_alusrc), .ex_branch(z_ex_branch),
    .ex_branchne(z_ex_branchne), .ex_link(z_ex_link), .ex_memread(z_ex_memread),
    .ex_memwrite(z_ex_memwrite), .ex_memtoreg(z_ex_memtoreg), .ex_regwrite(z_ex_regwrite),
    .ex_wreg(z_ex_wreg), .mem_memread(z_mem_memread), .mem_memwrite(z_mem_memwrite),
    .mem_memtoreg(z_mem_memtoreg), .mem_regwrite(z_mem_regwrite), .mem_link(z_mem_link),
    .mem_wreg(z_mem_wreg), .wb_memtoreg(z_wb_memtoreg), .wb_regwrite(z_wb_regwrite),
    .wb_link(z_wb_link), .wb_wreg(z_wb_wreg), .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt),
    .illegal_seen(z_illegal_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    aluop;
    logic          alusrc;
    logic          branch;
    logic          branchne;
    logic          link;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          regwrite;
    logic [AW-1:0] wreg;
  } bun_t;

  typedef struct {
    int   due;
    bun_t b;
  } exp_t;

  exp_t ex_q[$];
  exp_t wb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05, JAL = 6'h03;
  localparam logic [5:0] RT = 6'h00, ADDI = 6'h08, ORI = 6'h0d;
  localparam bun_t BUBBLE = '0;

  always @(posedge clk) cyc++;

  // Reference decode for EXT_OPS = 1, written as a flat opcode table.
  function automatic bun_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    bun_t b;
    b = '0;
    case (op)
      6'h00: begin b.aluop = 3'b010; b.regwrite = (fn != 6'h08); b.wreg = (fn != 6'h08) ? rd : '0; end
      6'h23: begin b.alusrc = 1; b.memread = 1; b.memtoreg = 1; b.regwrite = 1; b.wreg = rt; end
      6'h2b: begin b.alusrc = 1; b.memwrite = 1; end
      6'h04: begin b.aluop = 3'b001; b.branch = 1; end
      6'h05: begin b.aluop = 3'b001; b.branch = 1; b.branchne = 1; end
      6'h03: begin b.link = 1; b.regwrite = 1; b.wreg = 5'd31; end
      6'h08: begin b.alusrc = 1; b.regwrite = 1; b.wreg = rt; end
      6'h0a: begin b.aluop = 3'b101; b.alusrc = 1; b.regwrite = 1; b.wreg = rt; end
      6'h0c: begin b.aluop = 3'b011; b.alusrc = 1; b.regwrite = 1; b.wreg = rt; end
      6'h0d: begin b.aluop = 3'b100; b.alusrc = 1; b.regwrite = 1; b.wreg = rt; end
      6'h0f: begin b.aluop = 3'b110; b.alusrc = 1; b.regwrite = 1; b.wreg = rt; end
      default: b = '0;
    endcase
    return b;
  endfunction

  // Record what the instruction driven this cycle should look like in EX and WB.
  task automatic push(input bun_t b);
    exp_t e;
    e.due = cyc + 1;
    e.b = b;
    ex_q.push_back(e);
    e.due = cyc + 3;
    wb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic z);
    @(posedge clk);
    #1;
    id_valid = v; opcode = op; funct = fn; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    id_valid = 1'b0; opcode = '0; funct = '0; id_rs = '0; id_rt = '0; id_rd = '0; ex_zero = 1'b0;
    ex_q.delete();
    wb_q.delete();
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Scoreboard: compare EX and WB bundles against entries due this cycle.
  always @(negedge clk) begin : sb
    exp_t e;
    bun_t got;
    if (!rst_n) begin
      ex_q.delete();
      wb_q.delete();
    end else begin
      if (ex_q.size() > 0 && ex_q[0].due == cyc) begin
        e = ex_q.pop_front();
        got = '0;
        got.aluop = ex_aluop; got.alusrc = ex_alusrc; got.branch = ex_branch;
        got.branchne = ex_branchne; got.link = ex_link; got.memread = ex_memread;
        got.memwrite = ex_memwrite; got.memtoreg = ex_memtoreg; got.regwrite = ex_regwrite;
        got.wreg = ex_wreg;
        n_checks++;
        if (got !== e.b) $display("FAIL ex_bundle cyc=%0d got=%h exp=%h", cyc, got, e.b);
        else n_pass++;
      end
      if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
        e = wb_q.pop_front();
        n_checks++;
        if ({wb_memtoreg, wb_regwrite, wb_link, wb_wreg} !== {e.b.memtoreg, e.b.regwrite, e.b.link, e.b.wreg})
          $display("FAIL wb_bundle cyc=%0d got=%b%b%b/%0d exp=%b%b%b/%0d", cyc,
                   wb_memtoreg, wb_regwrite, wb_link, wb_wreg,
                   e.b.memtoreg, e.b.regwrite, e.b.link, e.b.wreg);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    #2;
    id_valid = 1'b1; opcode = JAL;
    #1;
    n_checks++; if ({stall, ex_br_taken} !== 2'b00) $display("FAIL rst_stall_br got=%b exp=00", {stall, ex_br_taken}); else n_pass++;
    n_checks++; if ({ex_regwrite, ex_memread, ex_wreg} !== '0) $display("FAIL rst_ex got=%h exp=0", {ex_regwrite, ex_memread, ex_wreg}); else n_pass++;
    n_checks++; if ({mem_regwrite, mem_memwrite, wb_regwrite, wb_link, wb_wreg} !== '0) $display("FAIL rst_memwb got=%h exp=0", {mem_regwrite, mem_memwrite, wb_regwrite, wb_link, wb_wreg}); else n_pass++;
    n_checks++; if ({stall_cnt, flush_cnt, illegal_seen} !== '0) $display("FAIL rst_cnt got=%h exp=0", {stall_cnt, flush_cnt, illegal_seen}); else n_pass++;
    n_checks++; if (pc_jump !== 1'b1) $display("FAIL rst_comb_pc_jump got=%b exp=1", pc_jump); else n_pass++;
    id_valid = 1'b0; opcode = '0;
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, LW, 6'h00, 5'd1, 5'd8, 5'd0, 0); push(model(LW, 6'h00, 5'd8, 5'd0));
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_lw_stall got=%b exp=0", stall); else n_pass++;
    drive(1, RT, 6'h20, 5'd8, 5'd2, 5'd9, 0); push(BUBBLE);
    @(negedge clk);
    n_checks++; if ({stall, pc_jump, flush_ifid} !== 3'b100) $display("FAIL lu_add_stall got=%b exp=100", {stall, pc_jump, flush_ifid}); else n_pass++;
    drive(1, RT, 6'h20, 5'd8, 5'd2, 5'd9, 0); push(model(RT, 6'h20, 5'd2, 5'd9));
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_add_release got=%b exp=0", stall); else n_pass++;
    drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
    @(negedge clk);
    n_checks++; if (stall_cnt !== 4'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); else n_pass++;
  endtask

  task automatic test_reg_zero();
    drive(1, LW, 6'h00, 5'd1, 5'd0, 5'd0, 0); push(model(LW, 6'h00, 5'd0, 5'd0));
    drive(1, RT, 6'h20, 5'd0, 5'd0, 5'd3, 0); push(model(RT, 6'h20, 5'd0, 5'd3));
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL r0_no_stall got=%b exp=0", stall); else n_pass++;
    drive(1, SW, 6'h00, 5'd4, 5'd5, 5'd0, 0); push(model(SW, 6'h00, 5'd5, 5'd0));
    drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
    @(negedge clk);
    n_checks++; if (stall_cnt !== 4'd1) $display("FAIL r0_stall_cnt got=%0d exp=1", stall_cnt); else n_pass++;
  endtask

  task automatic test_branch_flush();
    do_reset();
    drive(1, BEQ, 6'h00, 5'd1, 5'd2, 5'd0, 0); push(model(BEQ, 6'h00, 5'd2, 5'd0));
    @(negedge clk);
    n_checks++; if ({stall, flush_ifid} !== 2'b00) $display("FAIL br_beq_id got=%b exp=00", {stall, flush_ifid}); else n_pass++;
    drive(1, JAL, 6'h00, 5'd0, 5'd0, 5'd0, 1); push(BUBBLE);
    @(negedge clk);
    n_checks++; if ({ex_br_taken, flush_ifid, pc_jump, stall} !== 4'b1100) $display("FAIL br_taken got=%b exp=1100", {ex_br_taken, flush_ifid, pc_jump, stall}); else n_pass++;
    drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
    @(negedge clk);
    n_checks++; if ({ex_br_taken, flush_cnt} !== {1'b0, 4'd1}) $display("FAIL br_flush_cnt got=%b/%0d exp=0/1", ex_br_taken, flush_cnt); else n_pass++;
    drive(1, BNE, 6'h00, 5'd1, 5'd2, 5'd0, 0); push(model(BNE, 6'h00, 5'd2, 5'd0));
    drive(1, RT, 6'h22, 5'd3, 5'd4, 5'd5, 1); push(model(RT, 6'h22, 5'd4, 5'd5));
    @(negedge clk);
    n_checks++; if ({ex_br_taken, flush_ifid} !== 2'b00) $display("FAIL bne_not_taken got=%b exp=00", {ex_br_taken, flush_ifid}); else n_pass++;
    drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
  endtask

  task automatic test_jump();
    do_reset();
    drive(1, JAL, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(model(JAL, 6'h00, 5'd0, 5'd0));
    @(negedge clk);
    n_checks++; if ({pc_jump, flush_ifid, pc_jumpr, stall} !== 4'b1100) $display("FAIL jal_id got=%b exp=1100", {pc_jump, flush_ifid, pc_jumpr, stall}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
    end
    @(negedge clk);
    n_checks++; if ({wb_wreg, wb_link, wb_regwrite} !== {5'd31, 1'b1, 1'b1}) $display("FAIL jal_wb got=%0d/%b/%b exp=31/1/1", wb_wreg, wb_link, wb_regwrite); else n_pass++;
    n_checks++; if (flush_cnt !== 4'd1) $display("FAIL jal_flush_cnt got=%0d exp=1", flush_cnt); else n_pass++;
    drive(1, LW, 6'h00, 5'd1, 5'd5, 5'd0, 0); push(model(LW, 6'h00, 5'd5, 5'd0));
    drive(1, RT, 6'h08, 5'd5, 5'd0, 5'd0, 0); push(BUBBLE);
    @(negedge clk);
    n_checks++; if ({stall, pc_jump, flush_ifid} !== 3'b100) $display("FAIL jr_hazard got=%b exp=100", {stall, pc_jump, flush_ifid}); else n_pass++;
    drive(1, RT, 6'h08, 5'd5, 5'd0, 5'd0, 0); push(model(RT, 6'h08, 5'd0, 5'd0));
    @(negedge clk);
    n_checks++; if ({pc_jump, pc_jumpr, flush_ifid, stall} !== 4'b1110) $display("FAIL jr_id got=%b exp=1110", {pc_jump, pc_jumpr, flush_ifid, stall}); else n_pass++;
    drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
    @(negedge clk);
    n_checks++; if (flush_cnt !== 4'd2) $display("FAIL jr_flush_cnt got=%0d exp=2", flush_cnt); else n_pass++;
  endtask

  task automatic test_ext_ops();
    do_reset();
    drive(1, ORI, 6'h00, 5'd2, 5'd7, 5'd0, 0); push(model(ORI, 6'h00, 5'd7, 5'd0));
    @(negedge clk);
    n_checks++; if ({illegal, id_signext, z_illegal} !== 3'b001) $display("FAIL ori_id got=%b exp=001", {illegal, id_signext, z_illegal}); else n_pass++;
    drive(1, ADDI, 6'h00, 5'd2, 5'd6, 5'd0, 0); push(model(ADDI, 6'h00, 5'd6, 5'd0));
    @(negedge clk);
    n_checks++; if (ex_aluop !== 3'b100) $display("FAIL ori_aluop got=%b exp=100", ex_aluop); else n_pass++;
    n_checks++; if ({z_ex_regwrite, z_ex_alusrc, z_ex_aluop, z_ex_wreg} !== '0) $display("FAIL ori_ext0_bubble got=%h exp=0", {z_ex_regwrite, z_ex_alusrc, z_ex_aluop, z_ex_wreg}); else n_pass++;
    n_checks++; if ({id_signext, z_illegal_seen, illegal_seen} !== 3'b110) $display("FAIL addi_id got=%b exp=110", {id_signext, z_illegal_seen, illegal_seen}); else n_pass++;
    drive(1, 6'h3f, 6'h00, 5'd1, 5'd1, 5'd1, 0); push(BUBBLE);
    @(negedge clk);
    n_checks++; if (illegal !== 1'b1) $display("FAIL unmapped_illegal got=%b exp=1", illegal); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
    end
    @(negedge clk);
    n_checks++; if ({illegal_seen, z_illegal_seen, illegal} !== 3'b110) $display("FAIL illegal_sticky got=%b exp=110", {illegal_seen, z_illegal_seen, illegal}); else n_pass++;
    do_reset();
    @(negedge clk);
    n_checks++; if ({illegal_seen, z_illegal_seen} !== 2'b00) $display("FAIL illegal_cleared got=%b exp=00", {illegal_seen, z_illegal_seen}); else n_pass++;
  endtask

  task automatic test_saturate_async();
    logic ex_load;
    logic exp_stall;
    int   n_stall;
    do_reset();
    ex_load = 1'b0;
    n_stall = 0;
    for (int i = 0; i < 42; i++) begin
      drive(1, LW, 6'h00, 5'd8, 5'd8, 5'd0, 0);
      exp_stall = ex_load;
      if (exp_stall) begin
        push(BUBBLE);
        n_stall++;
      end else begin
        push(model(LW, 6'h00, 5'd8, 5'd0));
      end
      ex_load = ~exp_stall;
      @(negedge clk);
      n_checks++; if (stall !== exp_stall) $display("FAIL sat_stall i=%0d got=%b exp=%b", i, stall, exp_stall); else n_pass++;
    end
    drive(1, LW, 6'h00, 5'd8, 5'd8, 5'd0, 0); push(model(LW, 6'h00, 5'd8, 5'd0));
    @(negedge clk);
    n_checks++; if (stall_cnt !== ((n_stall > 15) ? 4'd15 : 4'(n_stall))) $display("FAIL sat_stall_cnt got=%0d exp=15", stall_cnt); else n_pass++;
    drive(1, LW, 6'h00, 5'd8, 5'd8, 5'd0, 0);
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL async_pre_stall got=%b exp=1", stall); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({stall, stall_cnt, flush_cnt, illegal_seen} !== '0) $display("FAIL async_stall_cnt got=%b/%0d/%0d/%b exp=0/0/0/0", stall, stall_cnt, flush_cnt, illegal_seen); else n_pass++;
    n_checks++; if ({ex_memread, ex_regwrite, ex_memtoreg, ex_alusrc, ex_wreg} !== '0) $display("FAIL async_ex got=%h exp=0", {ex_memread, ex_regwrite, ex_memtoreg, ex_alusrc, ex_wreg}); else n_pass++;
    n_checks++; if ({mem_memread, mem_regwrite, mem_wreg, wb_regwrite, wb_memtoreg, wb_wreg} !== '0) $display("FAIL async_memwb got=%h exp=0", {mem_memread, mem_regwrite, mem_wreg, wb_regwrite, wb_memtoreg, wb_wreg}); else n_pass++;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0); push(BUBBLE);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch_flush();
    test_jump();
    test_ext_ops();
    test_saturate_async();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
